jesd_tx_link_ctrl: RTL and testbench
====================================

// Module: jesd_tx_link_ctrl
// PURPOSE
// - JESD204B-style TX link-layer sequencer sitting between the 8-lane transport framer and the lane serialisers.
// - Runs the link bring-up: CGS (/K/), then ILAS (4 multiframes), then DATA.
// - In DATA it passes framer octets and applies alignment-character substitution (/F/, /A/).
// - Handles SYNC~ requests and keeps the LMFC; paces the framer through framer_en / framer_phase.
// PARAMETERS
// - F_OCT         4    octets per frame per lane (framer rhythm); power of 2
// - K_FRM         32   frames per multiframe; F_OCT*K_FRM <= 256
// - ILAS_MF       4    multiframes in ILAS
// - REINIT_CYC    20   consecutive sync low cycles that force re-init (5 frames)
// PORTS
// - clk           in   1    link clock, one octet per lane per cycle
// - rst_n         in   1    async active-low reset
// - link_en       in   1    enable link; 0 -> IDLE
// - sync_n        in   1    SYNC~ from RX, asynchronous, active-low
// - cfg_bytes     in   112  ILAS config octets 0..13, byte n = [8n+7:8n]
// - lane_in       in   64   framer octets, lane i = [8i+7:8i]
// - framer_en     out  1    framer may emit data
// - framer_phase  out  2    octet-in-frame index framer emits next cycle
// - lane_out      out  64   octets to serialisers
// - charisk       out  8    per-lane K-character flag
// - link_state    out  2    0 IDLE, 1 CGS, 2 ILAS, 3 DATA
// - sync_err_cnt  out  8    short SYNC~ pulse count, saturating
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, LMFC counter 0, sync synchroniser flops 1 (deasserted).
// - sync_n passes through a 2-FF synchroniser -> sync_s; all decisions use sync_s.
// - LMFC: octet counter 0..F_OCT*K_FRM-1, free-running from reset and wrapping.
//   - frame index = cnt/F_OCT; octet index = cnt%F_OCT.
// - Output latency: lane_out/charisk registered, one cycle after the state/lane_in they reflect.
// - IDLE: lane_out=0, charisk=0; link_en=1 -> CGS next cycle.
// - CGS: all lanes 0xBC (K28.5), charisk=8'hFF.
//   - Stay while sync_s=0.
//   - Once sync_s=1 seen, enter ILAS on the cycle LMFC=0.
// - ILAS: ILAS_MF multiframes, octet m within multiframe, charisk only on K chars:
//   - m=0: /R/ 0x1C
//   - last m: /A/ 0x7C
//   - multiframe 1, m=1: /Q/ 0x9C
//   - multiframe 1, m=2..15: cfg_bytes[m-2]; on lane i, byte 1 bits[4:0] = i (LID)
//   - all other m: m[7:0]
// - DATA: entered at LMFC=0 after the final ILAS /A/.
//   - framer_en=1 from the last ILAS cycle onward, so lane_in is valid on the first DATA cycle.
//   - framer_phase = octet index of LMFC+1.
//   - Non-final octet of a frame: lane_out=lane_in, charisk=0.
//   - Frame-final octet per lane: if it equals that lane's previous frame-final octet (original data, not the substituted value):
//     - end of multiframe -> 0x7C (/A/), charisk=1
//     - otherwise -> 0xFC (/F/), charisk=1
//     - else pass through.
//   - Previous-octet valid flags are cleared on DATA entry; no substitution in the first frame.
// - SYNC~ in ILAS/DATA:
//   - sync_s low for REINIT_CYC consecutive cycles -> CGS; framer_en=0 the same cycle.
//   - Shorter low pulse: sync_err_cnt+1 (saturate at 255) on its rising edge; state unchanged.
//   - sync_err_cnt cleared only by reset.
// - link_en=0 in any state -> IDLE next cycle, outputs 0; LMFC keeps running.
// - rst_n mid-operation: immediate return to reset values.
// STRUCTURE
// - Package jesd_tx_pkg: K-char constants (K28_5, K28_0, K28_3, K28_4, K28_7), link_state enum.
// - Sub-module jesd_align_char: one lane's frame-final compare/substitute plus previous-octet register.
//   - Instantiated 8 times, inputs: eof, eomf, clr.
// - Top: synchroniser, LMFC counter, state FSM, ILAS octet generator, sync-error counter.
// TESTING
// - link_en=1, sync_n=0 for 300 cycles -> every lane 0xBC, charisk=FF, link_state=1.
// - Release sync_n at LMFC=50 -> ILAS starts at next LMFC=0; octet0=0x1C, octet127=0x7C.
//   - MF1 octet1=0x9C; lane5 LID=5; DATA begins 512 cycles later.
// - DATA, lane_in constant 0x55 all lanes:
//   - first frame passes unchanged;
//   - later frame-final octets become 0xFC, and 0x7C at octet 127, with charisk set.
// - DATA, sync_n low 8 cycles -> sync_err_cnt=1, stays DATA.
//   - Low 24 cycles -> CGS, framer_en=0.
// - link_en dropped mid-ILAS -> IDLE next cycle, lane_out=0.
//   - rst_n pulse in DATA -> all outputs 0, sync_err_cnt=0.

Source files
------------

// File: rtl/jesd_tx_pkg.sv
// Shared constants and types for the JESD204B-style TX link-layer sequencer.
package jesd_tx_pkg;
  localparam int F_OCT      = 4;
  localparam int K_FRM      = 32;
  localparam int ILAS_MF    = 4;
  localparam int REINIT_CYC = 20;
  localparam int LANES      = 8;
  localparam int LMFC_LEN   = F_OCT * K_FRM;
  localparam int CNT_W      = $clog2(LMFC_LEN);
  localparam int OCT_W      = $clog2(F_OCT);
  localparam int MF_W       = $clog2(ILAS_MF);
  localparam int LOW_W      = $clog2(REINIT_CYC + 1);

  localparam logic [7:0] K28_5 = 8'hBC;  // /K/ comma
  localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
  localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config start
  localparam logic [7:0] K28_7 = 8'hFC;  // /F/ frame end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CGS  = 2'd1,
    ST_ILAS = 2'd2,
    ST_DATA = 2'd3
  } link_state_e;
endpackage

// File: rtl/jesd_align_char.sv
// One lane's frame-final alignment-character substitution; remembers the
// original (unsubstituted) frame-final octet of the previous frame.
module jesd_align_char
  import jesd_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       eof_i,
  input  logic       eomf_i,
  input  logic [7:0] oct_i,
  output logic [7:0] oct_o,
  output logic       k_o
);
  logic [7:0] prev_q;
  logic       vld_q;
  logic       hit;

  assign hit   = eof_i && vld_q && (oct_i == prev_q);
  assign oct_o = hit ? (eomf_i ? K28_3 : K28_7) : oct_i;
  assign k_o   = hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      vld_q  <= 1'b0;
    end else if (clr_i) begin
      vld_q  <= 1'b0;
    end else if (eof_i) begin
      prev_q <= oct_i;
      vld_q  <= 1'b1;
    end
  end
endmodule

// File: rtl/jesd_tx_link_ctrl.sv
// TX link-layer sequencer: CGS -> ILAS -> DATA bring-up, LMFC keeping,
// alignment-character insertion and SYNC~ supervision for 8 lanes.
module jesd_tx_link_ctrl
  import jesd_tx_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         link_en,
  input  logic         sync_n,
  input  logic [111:0] cfg_bytes,
  input  logic [63:0]  lane_in,
  output logic         framer_en,
  output logic [1:0]   framer_phase,
  output logic [63:0]  lane_out,
  output logic [7:0]   charisk,
  output logic [1:0]   link_state,
  output logic [7:0]   sync_err_cnt
);
  logic                       sync_m_q, sync_s_q;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  link_state_e                state_q, state_d;
  logic                       seen_q, seen_d;
  logic [MF_W-1:0]            mf_q, mf_d;
  logic [LOW_W-1:0]           low_q, low_d;
  logic [7:0]                 err_q, err_d;
  logic [63:0]                lane_out_q, lane_out_d;
  logic [7:0]                 charisk_q, charisk_d;

  logic                       lmfc_last, eof, ilas_last, in_link, reinit;
  logic [OCT_W-1:0]           nxt_oct;
  logic [7:0]                 cfg_arr [16];
  logic [3:0]                 cfg_idx;
  logic [LANES-1:0][7:0]      ilas_oct, data_oct;
  logic [LANES-1:0]           ilas_k, data_k;

  assign lmfc_last = (cnt_q == CNT_W'(LMFC_LEN - 1));
  assign cnt_d     = lmfc_last ? '0 : cnt_q + 1'b1;
  assign eof       = (cnt_q[OCT_W-1:0] == OCT_W'(F_OCT - 1));
  assign ilas_last = (state_q == ST_ILAS) && (mf_q == MF_W'(ILAS_MF - 1)) && lmfc_last;
  assign in_link   = (state_q == ST_ILAS) || (state_q == ST_DATA);
  assign reinit    = in_link && !sync_s_q && (low_q == LOW_W'(REINIT_CYC - 1));

  // Framer handshake: framer_en high in cycle t means lane_in carries valid
  // octets in cycle t+1, at octet-in-frame index framer_phase.
  assign nxt_oct      = cnt_q[OCT_W-1:0] + 1'b1;
  assign framer_en    = (state_q == ST_DATA) || ilas_last;
  assign framer_phase = framer_en ? nxt_oct : '0;

  assign lane_out     = lane_out_q;
  assign charisk      = charisk_q;
  assign link_state   = state_q;
  assign sync_err_cnt = err_q;

  always_comb begin
    state_d = state_q;
    seen_d  = 1'b0;
    mf_d    = '0;
    case (state_q)
      ST_IDLE: state_d = ST_CGS;
      ST_CGS: begin
        seen_d = seen_q | sync_s_q;
        if ((seen_q || sync_s_q) && lmfc_last) state_d = ST_ILAS;
      end
      ST_ILAS: begin
        mf_d = lmfc_last ? mf_q + 1'b1 : mf_q;
        if (ilas_last) state_d = ST_DATA;
      end
      default: ;
    endcase
    if (reinit)   state_d = ST_CGS;
    if (!link_en) state_d = ST_IDLE;
  end

  // A low run that ends before the re-init threshold counts as a sync error.
  always_comb begin
    low_d = (in_link && !sync_s_q) ? low_q + 1'b1 : '0;
    err_d = err_q;
    if (in_link && sync_s_q && (low_q != '0) && (low_q < LOW_W'(REINIT_CYC)) && (err_q != 8'hFF))
      err_d = err_q + 1'b1;
  end

  always_comb begin
    for (int b = 0; b < 14; b++) cfg_arr[b] = cfg_bytes[8*b +: 8];
    cfg_arr[14] = 8'h00;
    cfg_arr[15] = 8'h00;
    cfg_idx = 4'(cnt_q - CNT_W'(2));
    for (int i = 0; i < LANES; i++) begin
      ilas_oct[i] = 8'(cnt_q);
      ilas_k[i]   = 1'b0;
      if (cnt_q == '0) begin
        ilas_oct[i] = K28_0;
        ilas_k[i]   = 1'b1;
      end else if (lmfc_last) begin
        ilas_oct[i] = K28_3;
        ilas_k[i]   = 1'b1;
      end else if (mf_q == MF_W'(1) && cnt_q == CNT_W'(1)) begin
        ilas_oct[i] = K28_4;
        ilas_k[i]   = 1'b1;
      end else if (mf_q == MF_W'(1) && cnt_q <= CNT_W'(15)) begin
        ilas_oct[i] = cfg_arr[cfg_idx];
        if (cnt_q == CNT_W'(3)) ilas_oct[i][4:0] = 5'(i);
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    jesd_align_char u_align (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (state_q != ST_DATA),
      .eof_i  (eof),
      .eomf_i (lmfc_last),
      .oct_i  (lane_in[8*g +: 8]),
      .oct_o  (data_oct[g]),
      .k_o    (data_k[g])
    );
  end

  always_comb begin
    lane_out_d = '0;
    charisk_d  = '0;
    if (link_en) begin
      case (state_q)
        ST_CGS: begin
          lane_out_d = {LANES{K28_5}};
          charisk_d  = '1;
        end
        ST_ILAS: begin
          lane_out_d = ilas_oct;
          charisk_d  = ilas_k;
        end
        ST_DATA: begin
          lane_out_d = data_oct;
          charisk_d  = data_k;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_m_q   <= 1'b1;
      sync_s_q   <= 1'b1;
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      seen_q     <= 1'b0;
      mf_q       <= '0;
      low_q      <= '0;
      err_q      <= '0;
      lane_out_q <= '0;
      charisk_q  <= '0;
    end else begin
      sync_m_q   <= sync_n;
      sync_s_q   <= sync_m_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      seen_q     <= seen_d;
      mf_q       <= mf_d;
      low_q      <= low_d;
      err_q      <= err_d;
      lane_out_q <= lane_out_d;
      charisk_q  <= charisk_d;
    end
  end
endmodule

// File: tb/tb_jesd_tx_link_ctrl.sv
// Bench for jesd_tx_link_ctrl: directed bring-up scenarios plus a behavioural
// reference model compared against the outputs every cycle.
module tb_jesd_tx_link_ctrl;
  localparam int LMFC   = 128;
  localparam int ILAS_N = 4 * LMFC;
  localparam int REINIT = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         link_en = 1'b0;
  logic         sync_n = 1'b1;
  logic [111:0] cfg_bytes = '0;
  logic [63:0]  lane_in = '0;
  logic         framer_en;
  logic [1:0]   framer_phase;
  logic [63:0]  lane_out;
  logic [7:0]   charisk;
  logic [1:0]   link_state;
  logic [7:0]   sync_err_cnt;

  jesd_tx_link_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .link_en      (link_en),
    .sync_n       (sync_n),
    .cfg_bytes    (cfg_bytes),
    .lane_in      (lane_in),
    .framer_en    (framer_en),
    .framer_phase (framer_phase),
    .lane_out     (lane_out),
    .charisk      (charisk),
    .link_state   (link_state),
    .sync_err_cnt (sync_err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: state, LMFC position and per-lane history as plain integers.
  int          m_cnt = 0, m_state = 0, m_pos = 0, m_run = 0, m_err = 0, ns = 0;
  bit          m_s1 = 1'b1, m_s = 1'b1, m_seen = 1'b0, in_link = 1'b0;
  logic [7:0]  m_prev [8];
  bit          m_vld [8];
  logic [63:0] e_lane = '0, nl;
  logic [7:0]  e_k = '0, nk, b;
  logic [8:0]  r;

  function automatic logic [8:0] ilas_ref(input int pos, input int lane);
    int m;
    int mf;
    logic [7:0] o;
    m  = pos % LMFC;
    mf = pos / LMFC;
    if (m == 0) return {1'b1, 8'h1C};
    if (m == LMFC - 1) return {1'b1, 8'h7C};
    if (mf == 1 && m == 1) return {1'b1, 8'h9C};
    if (mf == 1 && m >= 2 && m <= 15) begin
      o = cfg_bytes[8*(m-2) +: 8];
      if (m == 3) o[4:0] = 5'(lane);
      return {1'b0, o};
    end
    return {1'b0, 8'(m)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_state = 0; m_pos = 0; m_run = 0; m_err = 0;
      m_s1 = 1'b1; m_s = 1'b1; m_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin m_prev[i] = '0; m_vld[i] = 1'b0; end
      e_lane = '0; e_k = '0;
    end else begin
      nl = '0; nk = '0;
      if (link_en) begin
        case (m_state)
          1: begin nl = {8{8'hBC}}; nk = 8'hFF; end
          2: for (int i = 0; i < 8; i++) begin
               r = ilas_ref(m_pos, i);
               nl[8*i +: 8] = r[7:0];
               nk[i] = r[8];
             end
          3: for (int i = 0; i < 8; i++) begin
               b = lane_in[8*i +: 8];
               nl[8*i +: 8] = b;
               if (m_cnt % 4 == 3 && m_vld[i] && b == m_prev[i]) begin
                 nl[8*i +: 8] = (m_cnt == LMFC - 1) ? 8'h7C : 8'hFC;
                 nk[i] = 1'b1;
               end
             end
          default: ;
        endcase
      end
      for (int i = 0; i < 8; i++) begin
        if (m_state != 3) m_vld[i] = 1'b0;
        else if (m_cnt % 4 == 3) begin m_prev[i] = lane_in[8*i +: 8]; m_vld[i] = 1'b1; end
      end
      in_link = (m_state == 2 || m_state == 3);
      ns = m_state;
      case (m_state)
        0: ns = 1;
        1: if ((m_seen || m_s) && m_cnt == LMFC - 1) ns = 2;
        2: if (m_pos == ILAS_N - 1) ns = 3;
        default: ;
      endcase
      if (in_link && !m_s && m_run + 1 == REINIT) ns = 1;
      if (!link_en) ns = 0;
      if (in_link && m_s && m_run > 0 && m_run < REINIT && m_err < 255) m_err++;
      m_run   = (in_link && !m_s) ? m_run + 1 : 0;
      m_seen  = (m_state == 1) && (m_seen || m_s);
      m_pos   = (m_state == 2) ? m_pos + 1 : 0;
      m_state = ns;
      m_cnt   = (m_cnt + 1) % LMFC;
      m_s     = m_s1;
      m_s1    = sync_n;
      e_lane  = nl;
      e_k     = nk;
    end
  end

  bit mon_en = 1'b0;
  bit e_fe;
  always @(negedge clk) begin
    if (mon_en) begin
      e_fe = (m_state == 3) || (m_state == 2 && m_pos == ILAS_N - 1);
      check("lane_out", lane_out, e_lane);
      check("charisk", 64'(charisk), 64'(e_k));
      check("link_state", 64'(link_state), 64'(m_state));
      check("framer_en", 64'(framer_en), 64'(e_fe));
      check("framer_phase", 64'(framer_phase), e_fe ? 64'((m_cnt + 1) % 4) : 64'd0);
      check("sync_err_cnt", 64'(sync_err_cnt), 64'(m_err));
    end
  end

  int data_mode = 0;

  task automatic step();
    @(negedge clk);
    if (data_mode == 2)
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 3))
          0, 1:    lane_in[8*i +: 8] = 8'h55;
          2:       lane_in[8*i +: 8] = 8'hAA;
          default: lane_in[8*i +: 8] = 8'($urandom);
        endcase
      end
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  task automatic wait_state(input int s, input int budget, input string tag);
    int k;
    k = 0;
    while (int'(link_state) != s && k < budget) begin step(); k++; end
    check(tag, 64'(link_state), 64'(s));
  endtask

  initial begin
    int k;
    int n_pulse;
    for (int i = 0; i < 14; i++) cfg_bytes[8*i +: 8] = 8'($urandom);
    cyc(3);
    check("rst_lane_out", lane_out, 64'd0);
    check("rst_charisk", 64'(charisk), 64'd0);
    check("rst_link_state", 64'(link_state), 64'd0);
    check("rst_framer_en", 64'(framer_en), 64'd0);
    check("rst_framer_phase", 64'(framer_phase), 64'd0);
    check("rst_sync_err", 64'(sync_err_cnt), 64'd0);
    #2 rst_n = 1'b1;
    mon_en  = 1'b1;
    link_en = 1'b1;
    sync_n  = 1'b0;

    cyc(300);
    check("cgs_lanes", lane_out, {8{8'hBC}});
    check("cgs_charisk", 64'(charisk), 64'hFF);
    check("cgs_state", 64'(link_state), 64'd1);

    k = 0;
    while (m_cnt != 50 && k < 200) begin step(); k++; end
    sync_n = 1'b0 | 1'b1;
    wait_state(2, 300, "ilas_entry");
    data_mode = 1;
    lane_in = {8{8'h55}};
    cyc(1);
    check("ilas_oct0", lane_out, {8{8'h1C}});
    check("ilas_oct0_k", 64'(charisk), 64'hFF);
    cyc(127);
    check("ilas_oct127", lane_out, {8{8'h7C}});
    cyc(2);
    check("ilas_mf1_q", lane_out, {8{8'h9C}});
    cyc(1);
    check("ilas_cfg0", 64'(lane_out[7:0]), 64'(cfg_bytes[7:0]));
    cyc(1);
    check("ilas_lid5", 64'(lane_out[47:40]), 64'({cfg_bytes[15:13], 5'd5}));
    check("ilas_cfg1_k", 64'(charisk), 64'd0);
    cyc(379);
    check("ilas_last_fen", 64'(framer_en), 64'd1);
    cyc(1);
    check("data_entry", 64'(link_state), 64'd3);

    cyc(4);
    check("data_frame0", lane_out, {8{8'h55}});
    check("data_frame0_k", 64'(charisk), 64'd0);
    cyc(4);
    check("data_f_sub", lane_out, {8{8'hFC}});
    check("data_f_sub_k", 64'(charisk), 64'hFF);
    cyc(1);
    check("data_nonfinal", lane_out, {8{8'h55}});
    cyc(119);
    check("data_a_sub", lane_out, {8{8'h7C}});
    check("data_a_sub_k", 64'(charisk), 64'hFF);

    data_mode = 2;
    cyc(200);
    sync_n = 1'b0;
    cyc(8);
    sync_n = 1'b1;
    cyc(6);
    check("short_sync_err", 64'(sync_err_cnt), 64'd1);
    check("short_sync_state", 64'(link_state), 64'd3);

    sync_n = 1'b0;
    cyc(24);
    check("reinit_state", 64'(link_state), 64'd1);
    check("reinit_fen", 64'(framer_en), 64'd0);
    sync_n = 1'b1;

    wait_state(2, 300, "ilas_reentry");
    cyc(10);
    link_en = 1'b0;
    cyc(1);
    check("link_off_state", 64'(link_state), 64'd0);
    check("link_off_lanes", lane_out, 64'd0);
    check("link_off_k", 64'(charisk), 64'd0);
    link_en = 1'b1;

    wait_state(3, 1000, "data_reentry");
    n_pulse = 4;
    for (int p = 0; p < n_pulse; p++) begin
      cyc($urandom_range(4, 12));
      sync_n = 1'b0;
      cyc($urandom_range(1, REINIT - 6));
      sync_n = 1'b1;
    end
    cyc(8);
    check("rand_sync_err", 64'(sync_err_cnt), 64'(1 + n_pulse));
    check("rand_sync_state", 64'(link_state), 64'd3);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_lanes", lane_out, 64'd0);
    check("midrst_k", 64'(charisk), 64'd0);
    check("midrst_state", 64'(link_state), 64'd0);
    check("midrst_fen", 64'(framer_en), 64'd0);
    check("midrst_err", 64'(sync_err_cnt), 64'd0);
    cyc(2);
    #2 rst_n = 1'b1;
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
